// File: rtl/merge_arb_pkg.sv
// rtl/merge_arb_pkg.sv - shared types and helpers for the merge selector arbiter
package merge_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;

  localparam logic SEL_L0 = 1'b0;
  localparam logic SEL_L1 = 1'b1;

  // A TIMEOUT of 0 still needs a 1-bit counter so the declaration stays legal.
  function automatic int tmo_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
  import merge_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) winner = ~last_grant;
    else if (req1)    winner = SEL_L1;
    else              winner = SEL_L0;
  end

endmodule

// File: rtl/merge_sel_arbiter.sv
// rtl/merge_sel_arbiter.sv - round-robin selector token issuer for a two-input merge
module merge_sel_arbiter
  import merge_arb_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic             sel,
  input  logic             pkt_done,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             timeout_err,
  output logic             spurious_err,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam int            TW      = tmo_w(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  arb_state_t    state;
  logic          last_grant;
  logic [TW-1:0] tmo_cnt;
  logic          any_req;
  logic          winner;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel_valid    <= 1'b0;
      sel          <= SEL_L0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      spurious_err <= 1'b0;
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
      last_grant   <= SEL_L1;
      tmo_cnt      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (pkt_done && state != BUSY) spurious_err <= 1'b1;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel       <= winner;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_ready) begin
            sel_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (pkt_done) begin
            if (sel == SEL_L0) begin
              ack0     <= 1'b1;
              gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            end else begin
              ack1     <= 1'b1;
              gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            end
            last_grant <= sel;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (TIMEOUT != 0 && tmo_cnt != TMO_MAX) begin
            // Saturating count; the flag is raised on the edge the count hits the limit.
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt + TW'(1) == TMO_MAX) timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
